fifo_cmd_conditioner: RTL and testbench

Front-end conditioner for the FIFO controller on the VGA FIFO board. Takes the raw active-low push-button and the read/write slide switch, synchronizes and debounces them, and emits a clean one-clock command pulse with a stable direction bit. Holding the button auto-repeats commands. The FIFO controller's button and RW inputs connect directly to `cmd_valid` and `cmd_rw`.

---
 rtl/fifo_cmd_conditioner_if.sv | 33 +++
 rtl/fifo_cmd_conditioner.sv | 184 ++++++++++++++++++
 tb/tb_fifo_cmd_conditioner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cmd_conditioner_if.sv
// Command-conditioner bus: raw push-button/switch inputs toward the
// conditioner and the clean command outputs toward the FIFO controller.
interface fifo_cmd_conditioner_if;
  logic button_n;   // raw push-button, 0 = pressed
  logic rw_sw;      // raw direction switch, 1 = write
  logic repeat_en;  // synchronous auto-repeat enable
  logic cmd_valid;  // one-clock command pulse
  logic cmd_rw;     // direction of the most recent command
  logic pressed;    // debounced button level
  logic repeating;  // auto-repeat in progress

  // Conditioner side
  modport slave (
    input  button_n,
    input  rw_sw,
    input  repeat_en,
    output cmd_valid,
    output cmd_rw,
    output pressed,
    output repeating
  );

  // Driver / observer side
  modport master (
    output button_n,
    output rw_sw,
    output repeat_en,
    input  cmd_valid,
    input  cmd_rw,
    input  pressed,
    input  repeating
  );
endinterface

// File: rtl/fifo_cmd_conditioner.sv
// Push-button command conditioner: synchronizes the raw button and direction
// switch, debounces the button, and emits one-clock command pulses with a
// captured direction bit. A held button auto-repeats when enabled.
module fifo_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000,
  parameter int unsigned CNT_W           = 32'd25
) (
  input  logic                   clock,
  input  logic                   reset,
  fifo_cmd_conditioner_if.slave  io
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_HELD     = 3'd2,
    S_REPEAT   = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  // Terminal counts are "last value before the event" so that the event
  // fires on the N-th counted cycle.
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic r_btn_meta;
  logic r_btn_sync;
  logic r_rw_meta;
  logic r_rw_sync;

  state_t           r_state;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_cmd_valid;
  logic             r_cmd_rw;
  logic             r_pressed;
  logic             r_repeating;

  logic w_press;
  logic w_rw;

  assign w_press = r_btn_sync;
  assign w_rw    = r_rw_sync;

  // Two-flop synchronizers; the only flops that see the raw pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_rw_meta  <= 1'b0;
      r_rw_sync  <= 1'b0;
    end else begin
      r_btn_meta <= ~io.button_n;
      r_btn_sync <= r_btn_meta;
      r_rw_meta  <= io.rw_sw;
      r_rw_sync  <= r_rw_meta;
    end
  end

  // Debounce / auto-repeat state machine with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_db_cnt    <= CNT_ZERO;
      r_rep_cnt   <= CNT_ZERO;
      r_cmd_valid <= 1'b0;
      r_cmd_rw    <= 1'b0;
      r_pressed   <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pressed   <= 1'b0;
          r_repeating <= 1'b0;
          r_rep_cnt   <= CNT_ZERO;
          if (w_press) begin
            // This sample is the first of the debounce run.
            r_db_cnt <= CNT_ONE;
            r_state  <= S_PRESS_DB;
          end else begin
            r_db_cnt <= CNT_ZERO;
          end
        end

        S_PRESS_DB: begin
          if (!w_press) begin
            r_db_cnt <= CNT_ZERO;
            r_state  <= S_IDLE;
          end else if (r_db_cnt >= DB_LAST) begin
            r_cmd_valid <= 1'b1;
            r_cmd_rw    <= w_rw;
            r_pressed   <= 1'b1;
            r_db_cnt    <= CNT_ZERO;
            r_rep_cnt   <= CNT_ZERO;
            r_state     <= S_HELD;
          end else begin
            r_db_cnt <= sat_inc(r_db_cnt);
          end
        end

        S_HELD: begin
          if (!w_press) begin
            r_db_cnt  <= CNT_ZERO;
            r_rep_cnt <= CNT_ZERO;
            r_state   <= S_REL_DB;
          end else if (io.repeat_en && (r_rep_cnt >= DELAY_LAST)) begin
            r_cmd_valid <= 1'b1;
            r_cmd_rw    <= w_rw;
            r_repeating <= 1'b1;
            r_rep_cnt   <= CNT_ZERO;
            r_state     <= S_REPEAT;
          end else begin
            r_rep_cnt <= sat_inc(r_rep_cnt);
          end
        end

        S_REPEAT: begin
          if (!w_press) begin
            r_repeating <= 1'b0;
            r_db_cnt    <= CNT_ZERO;
            r_rep_cnt   <= CNT_ZERO;
            r_state     <= S_REL_DB;
          end else if (!io.repeat_en) begin
            r_repeating <= 1'b0;
            r_rep_cnt   <= CNT_ZERO;
            r_state     <= S_HELD;
          end else if (r_rep_cnt >= PERIOD_LAST) begin
            r_cmd_valid <= 1'b1;
            r_cmd_rw    <= w_rw;
            r_rep_cnt   <= CNT_ZERO;
          end else begin
            r_rep_cnt <= sat_inc(r_rep_cnt);
          end
        end

        S_REL_DB: begin
          r_repeating <= 1'b0;
          if (w_press) begin
            // Bounce on release: back to held, no new command.
            r_db_cnt  <= CNT_ZERO;
            r_rep_cnt <= CNT_ZERO;
            r_state   <= S_HELD;
          end else if (r_db_cnt >= DB_LAST) begin
            r_db_cnt  <= CNT_ZERO;
            r_pressed <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_db_cnt <= sat_inc(r_db_cnt);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_db_cnt    <= CNT_ZERO;
          r_rep_cnt   <= CNT_ZERO;
          r_pressed   <= 1'b0;
          r_repeating <= 1'b0;
        end
      endcase
    end
  end

  assign io.cmd_valid = r_cmd_valid;
  assign io.cmd_rw    = r_cmd_rw;
  assign io.pressed   = r_pressed;
  assign io.repeating = r_repeating;

endmodule

// File: tb/tb_fifo_cmd_conditioner.sv
// Directed bench for fifo_cmd_conditioner with an in-bench behavioural model
// (run-length / age counters over the synchronized input history) compared
// every cycle, plus hand-computed pulse timings.
module tb_fifo_cmd_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  int pulse_cyc[$];
  bit pulse_rw[$];

  fifo_cmd_conditioner_if io();

  fifo_cmd_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: value equals the index of the most recent rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  bit m_d1, m_d2, m_r1, m_r2;
  bit m_pressed, m_rep, m_valid, m_rw;
  int m_run, m_rel, m_age;

  // Model: press accepted after D consecutive pressed samples, released after
  // D+1 consecutive released samples, repeats by age since last pulse.
  always @(posedge clock or negedge reset) begin
    bit p, v, np, nr;
    int run, rel, age;
    if (!reset) begin
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_r1 <= 1'b0; m_r2 <= 1'b0;
      m_pressed <= 1'b0; m_rep <= 1'b0; m_valid <= 1'b0; m_rw <= 1'b0;
      m_run <= 0; m_rel <= 0; m_age <= 0;
    end else begin
      p = m_d2; v = 1'b0; np = m_pressed; nr = m_rep;
      run = m_run; rel = m_rel; age = m_age;
      if (!np) begin
        if (p) begin
          run = run + 1;
          if (run == D) begin v = 1'b1; np = 1'b1; age = 0; run = 0; rel = 0; end
        end else begin
          run = 0;
        end
      end else if (!p) begin
        nr = 1'b0; age = 0;
        if (rel == D) begin np = 1'b0; rel = 0; end
        else rel = rel + 1;
      end else if (rel != 0) begin
        rel = 0; age = 0;
      end else if (nr && !io.repeat_en) begin
        nr = 1'b0; age = 0;
      end else if (io.repeat_en && (age + 1 >= (nr ? RP : RD))) begin
        v = 1'b1; nr = 1'b1; age = 0;
      end else begin
        age = (age >= 255) ? 255 : age + 1;
      end
      m_valid <= v;
      if (v) m_rw <= m_r2;
      m_pressed <= np; m_rep <= nr;
      m_run <= run; m_rel <= rel; m_age <= age;
      m_d1 <= ~io.button_n; m_d2 <= m_d1;
      m_r1 <= io.rw_sw;     m_r2 <= m_r1;
    end
  end

  // Per-cycle comparison against the model, and pulse log for literal checks.
  always @(negedge clock) begin
    checks = checks + 1;
    if (io.cmd_valid !== m_valid || io.cmd_rw !== m_rw ||
        io.pressed !== m_pressed || io.repeating !== m_rep) begin
      errors = errors + 1;
      $display("FAIL model cyc=%0d got v=%b rw=%b p=%b r=%b exp v=%b rw=%b p=%b r=%b",
               cyc, io.cmd_valid, io.cmd_rw, io.pressed, io.repeating,
               m_valid, m_rw, m_pressed, m_rep);
    end
    if (io.cmd_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_rw.push_back(io.cmd_rw);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, int'(io.cmd_valid), 0);
    chk({name, "_rw"},    int'(io.cmd_rw),    0);
    chk({name, "_pressed"}, int'(io.pressed), 0);
    chk({name, "_repeating"}, int'(io.repeating), 0);
  endtask

  initial begin
    int e0, n0;
    cyc = 0; checks = 0; errors = 0;
    io.button_n = 1'b1; io.rw_sw = 1'b0; io.repeat_en = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset held: wiggle inputs, outputs must stay 0.
    for (int i = 0; i < 6; i++) begin
      tick(1);
      io.button_n = i[0];
      io.rw_sw = ~i[0];
      io.repeat_en = i[1];
      chk_all_zero("rst_hold");
    end
    io.button_n = 1'b1; io.rw_sw = 1'b0; io.repeat_en = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(10);
    chk("rst_rel_pressed", int'(io.pressed), 0);
    chk("rst_rel_pulses", pulse_cyc.size(), 0);

    // Clean press, write direction.
    io.rw_sw = 1'b1;
    io.button_n = 1'b0;
    e0 = cyc; n0 = pulse_cyc.size();
    tick(10);
    chk("clean_count", pulse_cyc.size() - n0, 1);
    chk("clean_time", pulse_cyc[n0] - e0, 6);
    chk("clean_rw", int'(io.cmd_rw), 1);
    chk("clean_pressed", int'(io.pressed), 1);
    io.button_n = 1'b1;
    tick(10);
    chk("clean_rel_pressed", int'(io.pressed), 0);
    chk("clean_rel_count", pulse_cyc.size() - n0, 1);

    // Bounce on press: runs of 2 samples never qualify.
    n0 = pulse_cyc.size();
    for (int i = 0; i < 10; i++) begin
      io.button_n = i[0];
      tick(2);
    end
    chk("bounce_nopulse", pulse_cyc.size() - n0, 0);
    io.button_n = 1'b0;
    e0 = cyc;
    tick(10);
    chk("bounce_count", pulse_cyc.size() - n0, 1);
    chk("bounce_time", pulse_cyc[n0] - e0, 6);
    // Bounce on release: stays pressed, no pulse.
    for (int i = 0; i < 10; i++) begin
      io.button_n = ~i[0];
      tick(2);
    end
    chk("relbounce_pressed", int'(io.pressed), 1);
    io.button_n = 1'b1;
    tick(10);
    chk("relbounce_released", int'(io.pressed), 0);
    chk("relbounce_count", pulse_cyc.size() - n0, 1);

    // Auto-repeat with direction flip before the first repeat.
    io.repeat_en = 1'b1; io.rw_sw = 1'b0;
    tick(3);
    io.button_n = 1'b0;
    e0 = cyc; n0 = pulse_cyc.size();
    tick(10);
    io.rw_sw = 1'b1;
    tick(30);
    chk("rep_repeating", int'(io.repeating), 1);
    tick(20);
    io.button_n = 1'b1;
    tick(10);
    chk("rep_count", pulse_cyc.size() - n0, 6);
    chk("rep_t0", pulse_cyc[n0] - e0, 6);
    chk("rep_t1", pulse_cyc[n0 + 1] - e0, 26);
    chk("rep_t2", pulse_cyc[n0 + 2] - e0, 34);
    chk("rep_t5", pulse_cyc[n0 + 5] - e0, 58);
    chk("rep_rw0", int'(pulse_rw[n0]), 0);
    chk("rep_rw1", int'(pulse_rw[n0 + 1]), 1);
    chk("rep_rw5", int'(pulse_rw[n0 + 5]), 1);
    chk("rep_rel_repeating", int'(io.repeating), 0);

    // Switch change between commands leaves cmd_rw alone; no repeat when disabled.
    io.repeat_en = 1'b0; io.rw_sw = 1'b0;
    tick(5);
    chk("between_rw", int'(io.cmd_rw), 1);
    io.button_n = 1'b0;
    e0 = cyc; n0 = pulse_cyc.size();
    tick(10);
    io.rw_sw = 1'b1;
    tick(50);
    chk("norep_rw_hold", int'(io.cmd_rw), 0);
    io.button_n = 1'b1;
    tick(10);
    chk("norep_count", pulse_cyc.size() - n0, 1);
    chk("norep_time", pulse_cyc[n0] - e0, 6);

    // Dropping repeat_en mid-repeat restarts the delay from the drop.
    io.repeat_en = 1'b1;
    io.button_n = 1'b0;
    e0 = cyc; n0 = pulse_cyc.size();
    tick(30);
    io.repeat_en = 1'b0;
    tick(10);
    io.repeat_en = 1'b1;
    tick(15);
    io.button_n = 1'b1;
    tick(10);
    chk("endrop_count", pulse_cyc.size() - n0, 3);
    chk("endrop_t2", pulse_cyc[n0 + 2] - e0, 51);

    // Reset mid-repeat with the button held through release.
    io.button_n = 1'b0;
    tick(30);
    chk("midrst_repeating", int'(io.repeating), 1);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick(3);
    reset = 1'b1;
    e0 = cyc; n0 = pulse_cyc.size();
    tick(8);
    chk("postrst_count", pulse_cyc.size() - n0, 1);
    chk("postrst_time", pulse_cyc[n0] - e0, 6);
    chk("postrst_repeating", int'(io.repeating), 0);
    io.button_n = 1'b1; io.repeat_en = 1'b0;
    tick(10);
    chk("final_pressed", int'(io.pressed), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
